cnt_sched: RTL
==============

# cnt_sched

Scheduler that shares one `counter_ud` up/down counter among `NREQ` requesters. Each requester asks for a counting job (start value, direction, step count). The block arbitrates, loads the counter, lets it run for exactly the requested number of steps, then returns the final count and a wrap flag. It sits between testbench or system agents and the `cnt_if` signals of a single counter instance. Between jobs it freezes the free-running counter.

## Interface
- `WIDTH`, 4, counter width; must match the counter's `WIDTH`.
- `NREQ`, 4, number of requesters (2..8).
- `LEN_W`, 4, width of the step-count field.

- `clk`  in  1  clock; shared with the counter.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  NREQ  job request per requester; held high until that requester's `done`.
- `req_load`  in  NREQ*WIDTH  start value; requester i uses slice [i*WIDTH +: WIDTH].
- `req_down`  in  NREQ  direction per requester: 1 = count down, 0 = count up.
- `req_len`  in  NREQ*LEN_W  number of steps per requester.
- `gnt`  out  NREQ  one-hot; high from LOAD through DONE for the winning requester.
- `done`  out  NREQ  one-cycle pulse to the winner in DONE.
- `res_count`  out  WIDTH  final count; valid while `done` is high.
- `res_wrap`  out  1  high with `done` if the counter wrapped during the job.
- `busy`  out  1  high in any state other than IDLE.
- `cnt_load_en`  out  1  drives the counter's `load_en`.
- `cnt_load`  out  WIDTH  drives the counter's `load`.
- `cnt_down`  out  1  drives the counter's `down`.
- `cnt_count`  in  WIDTH  the counter's `count`.

## Operation
- The counter has no enable, so the block holds it by loading its own value. In IDLE and DONE: `cnt_load_en`=1, `cnt_load`=`cnt_count`, `cnt_down`=0. These outputs are combinational from state.
- FSM states: IDLE, LOAD, RUN, DONE.
  - **IDLE:** if any `req` is high, choose a winner and latch its load value, direction and length, then go to LOAD.
  - **LOAD:** `cnt_load_en`=1, `cnt_load`=latched start value. If the latched length is 0, go to DONE; otherwise set the step counter to the length and go to RUN.
  - **RUN:** `cnt_load_en`=0, `cnt_down`=latched direction. Decrement the step counter each cycle; when it reaches 1, go to DONE.
  - **DONE:** drive `done[winner]`, `res_count`=`cnt_count` and `res_wrap`. Clear the wrap flag, advance the round-robin pointer to winner+1 (mod `NREQ`), then go to IDLE.
- Arbitration is round-robin: the first high `req` at or after the pointer wins.
- Wrap detection: in RUN, set the sticky wrap flag when counting up with `cnt_count`=all ones, or counting down with `cnt_count`=0.
- `res_count` equals start ± len, modulo 2^WIDTH.
- If `req` falls mid-job, the job still completes and `done` still pulses.
- A requester that is still requesting in DONE is eligible again only after the other requesters, per the pointer.

## Timing
- Reset values: state=IDLE, pointer=0, `gnt`=0, `done`=0, `res_count`=0, `res_wrap`=0, `busy`=0. Counter-side outputs take their IDLE values.
- Reset asserted mid-job aborts immediately: no `done` pulse, and all state returns to the reset values. The counter keeps its present value only if its own reset is not also asserted.
- A request sampled at an edge in IDLE gives `gnt` at the next cycle (the LOAD cycle, t).
- With len>0: RUN occupies t+1..t+len and DONE is at t+len+1.
- With len=0: DONE is at t+1 and `res_count` equals the start value.
- A minimum of one IDLE cycle separates jobs, so throughput is len+3 cycles per job.

## Configuration
- `CNT_SCHED_PRIO_EN` defined: fixed priority, lowest index wins; the pointer is unused and is held at 0.
- `CNT_SCHED_PRIO_EN` not defined: round-robin arbitration as described in Operation.

## Test plan
- **Single up-count job:** req[0], load=0x3, up, len=4. `gnt[0]` at t; `done[0]` at t+5 with `res_count`=0x7 and `res_wrap`=0. The counter then holds 0x7 in IDLE.
- **Down-count with wrap:** req[1], load=0x1, down, len=3. `res_count`=0xE, `res_wrap`=1.
- **Zero-length job:** req[2], load=0xA, len=0. `done[2]` at t+1 with `res_count`=0xA; the counter never steps.
- **Round-robin fairness:** all four `req` high continuously. Grants go 0, 1, 2, 3, 0, and `gnt` is always one-hot.
- **Reset mid-job:** reset pulses during RUN of a len=8 job. `gnt`, `done` and `busy` read 0 after reset; no `done` pulse ever appears; the next job is granted to the lowest index.
- **Fixed priority (`CNT_SCHED_PRIO_EN` defined):** req[0] and req[1] both held high. req[0] wins every job and `done[1]` never pulses.

Source files
------------

// File: rtl/cnt_sched.sv
// Shares one up/down counter among NREQ requesters: arbitrates, loads, runs len steps, returns count/wrap.
// Build option: CNT_SCHED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module cnt_sched #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned LEN_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*WIDTH-1:0]  req_load,
  input  logic [NREQ-1:0]        req_down,
  input  logic [NREQ*LEN_W-1:0]  req_len,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic [WIDTH-1:0]       res_count,
  output logic                   res_wrap,
  output logic                   busy,
  output logic                   cnt_load_en,
  output logic [WIDTH-1:0]       cnt_load,
  output logic                   cnt_down,
  input  logic [WIDTH-1:0]       cnt_count
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDX_W:0] NREQ_V = (IDX_W+1)'(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_win;
  logic [IDX_W-1:0]   w_win;
  logic [IDX_W-1:0]   w_idx;
  logic [IDX_W:0]     w_sum;
  logic               w_any;
  logic [WIDTH-1:0]   r_load;
  logic               r_down;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_steps;
  logic               r_wrap;
  logic               w_wrap_hit;
  logic [WIDTH-1:0]   w_step_val;

  // Round-robin search: first requester at or after the pointer
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    w_sum = '0;
    w_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_ptr} + (IDX_W+1)'(k);
      if (w_sum >= NREQ_V) w_sum = w_sum - NREQ_V;
      w_idx = w_sum[IDX_W-1:0];
      if (!w_any && req[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_any) w_next = S_LOAD;
      S_LOAD: w_next = (r_len == '0) ? S_DONE : S_RUN;
      S_RUN:  if (r_steps == LEN_W'(1)) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Counter-side outputs; outside LOAD/RUN the counter reloads its own value to hold
  always_comb begin
    cnt_load_en = 1'b1;
    cnt_load    = cnt_count;
    cnt_down    = 1'b0;
    case (r_state)
      S_LOAD: cnt_load = r_load;
      S_RUN: begin
        cnt_load_en = 1'b0;
        cnt_down    = r_down;
      end
      default: ;
    endcase
  end

  assign w_wrap_hit = (r_state == S_RUN) && (r_down ? (cnt_count == '0) : (&cnt_count));
  assign w_step_val = r_down ? (cnt_count - WIDTH'(1)) : (cnt_count + WIDTH'(1));

  // Job registers and registered outputs; results are captured on the edge entering DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr     <= '0;
      r_win     <= '0;
      r_load    <= '0;
      r_down    <= 1'b0;
      r_len     <= '0;
      r_steps   <= '0;
      r_wrap    <= 1'b0;
      gnt       <= '0;
      done      <= '0;
      res_count <= '0;
      res_wrap  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done     <= '0;
      res_wrap <= 1'b0;
      busy     <= (w_next != S_IDLE);
      if (w_wrap_hit) r_wrap <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_win  <= w_win;
            r_load <= req_load[32'(w_win)*WIDTH +: WIDTH];
            r_down <= req_down[w_win];
            r_len  <= req_len[32'(w_win)*LEN_W +: LEN_W];
            gnt    <= NREQ'(1) << w_win;
          end
        end
        S_LOAD: begin
          r_steps <= r_len;
          if (r_len == '0) begin
            done      <= gnt;
            res_count <= r_load;
          end
        end
        S_RUN: begin
          r_steps <= r_steps - LEN_W'(1);
          if (r_steps == LEN_W'(1)) begin
            done      <= gnt;
            res_count <= w_step_val;
            res_wrap  <= r_wrap | w_wrap_hit;
          end
        end
        S_DONE: begin
          r_wrap <= 1'b0;
          gnt    <= '0;
`ifdef CNT_SCHED_PRIO_EN
          r_ptr  <= '0;
`else
          r_ptr  <= (r_win == IDX_W'(NREQ-1)) ? '0 : (r_win + IDX_W'(1));
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
